// File: rtl/rect_plotter_pkg.sv
// Shared types and constants for the rectangle plotter: state encoding,
// default screen geometry and the pixel record used on the plot interface.
package rect_plotter_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam int PIX_X_W   = 8;
  localparam int PIX_Y_W   = 7;
  localparam int PIX_COL_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAW  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [PIX_X_W-1:0]   x;
    logic [PIX_Y_W-1:0]   y;
    logic [PIX_COL_W-1:0] colour;
  } pixel_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x fastest) offset counter shared by rectangle draw and clear.
// cx_o/cy_o give the offset being issued this cycle; last_o flags the held (w-1,h-1).
import rect_plotter_pkg::*;

module raster_counter #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic          enable_i,
  input  logic [CW-1:0] w_i,
  input  logic [CW-1:0] h_i,
  output logic [CW-1:0] cx_o,
  output logic [CW-1:0] cy_o,
  output logic          last_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic          row_end;

  assign row_end = (cx_q == w_i - ONE);
  assign last_o  = row_end && (cy_q == h_i - ONE);

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable_i) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + ONE;
      end else begin
        cx_d = cx_q + ONE;
      end
    end
  end

  // Exposing next-state lets the owner register the pixel in the same edge.
  assign cx_o = cx_d;
  assign cy_o = cy_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle / full-screen-clear plotter, one pixel per clock in raster order.
// Optional screen-edge clipping is enabled by defining RECT_PLOTTER_CLIP_EN.
import rect_plotter_pkg::*;

module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int SZ_W     = 5,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [X_W-1:0]   i_x,
  input  logic [Y_W-1:0]   i_y,
  input  logic [SZ_W-1:0]  i_w,
  input  logic [SZ_W-1:0]  i_h,
  input  logic [COL_W-1:0] i_colour,
  output logic             o_busy,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [COL_W-1:0] o_colour,
  output logic             o_plot,
  output logic             o_done
);

  localparam int CW = max3(SZ_W, X_W, Y_W);

  logic [1:0]       state_q, state_d;
  logic [X_W-1:0]   x0_q, x0_d, ox_q, ox_d;
  logic [Y_W-1:0]   y0_q, y0_d, oy_q, oy_d;
  logic [CW-1:0]    w_q, w_d, h_q, h_d;
  logic [COL_W-1:0] col_q, col_d, ocol_q, ocol_d;
  logic             plot_q, plot_d;

  logic             run, accept, last;
  logic [CW-1:0]    cx, cy;
  logic [X_W-1:0]   bx, px;
  logic [Y_W-1:0]   by, py;
  logic             pin;

  assign run    = (state_q == ST_DRAW) || (state_q == ST_CLEAR);
  assign accept = (state_q == ST_IDLE) && (i_clear || i_start);

  // In IDLE the origin comes straight from the request so pixel 0 lands on the accept edge.
  assign bx = (state_q == ST_IDLE) ? (i_clear ? '0 : i_x) : x0_q;
  assign by = (state_q == ST_IDLE) ? (i_clear ? '0 : i_y) : y0_q;

  raster_counter #(.CW(CW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load_i   (accept),
    .enable_i (run && !last),
    .w_i      (w_q),
    .h_i      (h_q),
    .cx_o     (cx),
    .cy_o     (cy),
    .last_o   (last)
  );

`ifdef RECT_PLOTTER_CLIP_EN
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  assign sx  = {1'b0, bx} + (X_W+1)'(cx);
  assign sy  = {1'b0, by} + (Y_W+1)'(cy);
  assign px  = sx[X_W-1:0];
  assign py  = sy[Y_W-1:0];
  assign pin = (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));
`else
  assign px  = bx + X_W'(cx);
  assign py  = by + Y_W'(cy);
  assign pin = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ocol_d  = ocol_q;
    plot_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          x0_d    = '0;
          y0_d    = '0;
          w_d     = CW'(SCREEN_W);
          h_d     = CW'(SCREEN_H);
          col_d   = i_colour;
          state_d = ST_CLEAR;
          ox_d    = px;
          oy_d    = py;
          ocol_d  = i_colour;
          plot_d  = pin;
        end else if (i_start) begin
          x0_d  = i_x;
          y0_d  = i_y;
          w_d   = CW'(i_w);
          h_d   = CW'(i_h);
          col_d = i_colour;
          if (i_w == '0 || i_h == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
            ox_d    = px;
            oy_d    = py;
            ocol_d  = i_colour;
            plot_d  = pin;
          end
        end
      end
      ST_DRAW, ST_CLEAR: begin
        if (last) begin
          state_d = ST_DONE;
        end else begin
          ox_d   = px;
          oy_d   = py;
          ocol_d = col_q;
          plot_d = pin;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      ocol_q  <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ocol_q  <= ocol_d;
      plot_q  <= plot_d;
    end
  end

  // Request fields are only meaningful once latched, so they carry no reset.
  always_ff @(posedge clock) begin
    x0_q  <= x0_d;
    y0_q  <= y0_d;
    w_q   <= w_d;
    h_q   <= h_d;
    col_q <= col_d;
  end

  assign o_x      = ox_q;
  assign o_y      = oy_q;
  assign o_colour = ocol_q;
  assign o_plot   = plot_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);

endmodule
